// File: rtl/servant_spi_ram_slave.sv
// SPI mode-0 serial SRAM target, oversampled in the clock domain.
// Build option SPI_RAM_STATUS_EN adds RDSR (0x05) and WRMR (0x01) with a byte/sequential mode register.
module servant_spi_ram_slave #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int SYNC_STAGES    = 2,
  parameter bit IDLE_MISO      = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      spi_sck,
  input  logic                      spi_ss,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  output logic                      busy,
  output logic                      wr_stb,
  output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]                wr_byte
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE_DATA, READ_DATA, IGNORE} state_t;

  localparam int         DEPTH     = 2 ** MEM_ADDR_WIDTH;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
`ifdef SPI_RAM_STATUS_EN
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;
`endif

  state_t                    state, state_d;
  logic                      sck_s, ss_s, mosi_s;
  logic                      sck_q, armed;
  logic                      sck_rise, sck_fall, ss_rise, ss_fall, byte_done;
  logic [2:0]                bit_cnt;
  logic [1:0]                addr_byte;
  logic [6:0]                rx;
  logic [7:0]                rx_next, tx;
  logic                      miso_q, is_write, mem_we;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr, next_addr, addr_shifted;
  logic [7:0]                addr_spill_unused;
  logic                      status_op, addr_inc;
  logic [7:0]                status_byte;
  logic [7:0]                mem [DEPTH];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sck_s  = spi_sck;
      assign ss_s   = spi_ss;
      assign mosi_s = spi_mosi;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sck_pipe, ss_pipe, mosi_pipe;
      // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          sck_pipe  <= '0;
          ss_pipe   <= '0;
          mosi_pipe <= '0;
        end else begin
          sck_pipe[0]  <= spi_sck;
          ss_pipe[0]   <= spi_ss;
          mosi_pipe[0] <= spi_mosi;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sck_pipe[i]  <= sck_pipe[i-1];
            ss_pipe[i]   <= ss_pipe[i-1];
            mosi_pipe[i] <= mosi_pipe[i-1];
          end
        end
      end
      assign sck_s  = sck_pipe[SYNC_STAGES-1];
      assign ss_s   = ss_pipe[SYNC_STAGES-1];
      assign mosi_s = mosi_pipe[SYNC_STAGES-1];
    end
  endgenerate

  // armed stays low after reset until ss is seen high, so a select held low through reset is not a fresh start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      sck_q <= sck_s;
      if (ss_s) armed <= 1'b1;
    end
  end

  assign sck_rise  = sck_s && !sck_q;
  assign sck_fall  = !sck_s && sck_q;
  assign ss_rise   = ss_s && (state != IDLE);
  assign ss_fall   = armed && !ss_s && (state == IDLE);
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign rx_next   = {rx, mosi_s};

  // Address bytes shift through the decoded width; bits pushed past the top alias away.
  assign {addr_spill_unused, addr_shifted} = {cur_addr, rx_next};
  assign next_addr = addr_inc ? cur_addr + MEM_ADDR_WIDTH'(1) : cur_addr;

`ifdef SPI_RAM_STATUS_EN
  logic [7:0] mode_reg;
  assign status_byte = mode_reg;
  assign addr_inc    = (mode_reg[7:6] != 2'b00);
`else
  assign status_op   = 1'b0;
  assign status_byte = 8'h00;
  assign addr_inc    = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (ss_fall) state_d = CMD;
        CMD: begin
          if (byte_done) begin
            case (rx_next)
              CMD_READ, CMD_WRITE: state_d = ADDR;
`ifdef SPI_RAM_STATUS_EN
              CMD_RDSR:            state_d = READ_DATA;
              CMD_WRMR:            state_d = WRITE_DATA;
`endif
              default:             state_d = IGNORE;
            endcase
          end
        end
        ADDR: if (byte_done && addr_byte == 2'd2) state_d = is_write ? WRITE_DATA : READ_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= 3'd0;
      addr_byte <= 2'd0;
      rx        <= 7'd0;
      tx        <= 8'd0;
      miso_q    <= IDLE_MISO;
      cur_addr  <= '0;
      is_write  <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_byte   <= 8'd0;
`ifdef SPI_RAM_STATUS_EN
      status_op <= 1'b0;
      mode_reg  <= 8'h40;
`endif
    end else begin
      wr_stb <= 1'b0;
      if (ss_rise) begin
        bit_cnt <= 3'd0;
        miso_q  <= IDLE_MISO;
      end else if (ss_fall) begin
        bit_cnt   <= 3'd0;
        addr_byte <= 2'd0;
      end else if (state != IDLE && state != IGNORE) begin
        if (sck_rise) begin
          rx      <= rx_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (sck_fall && state == READ_DATA) begin
          miso_q <= tx[7];
          tx     <= {tx[6:0], 1'b0};
        end
        if (byte_done) begin
          case (state)
            CMD: begin
              is_write <= (rx_next == CMD_WRITE);
`ifdef SPI_RAM_STATUS_EN
              status_op <= (rx_next == CMD_RDSR) || (rx_next == CMD_WRMR);
              if (rx_next == CMD_RDSR) tx <= mode_reg;
`endif
            end
            ADDR: begin
              addr_byte <= addr_byte + 2'd1;
              cur_addr  <= addr_shifted;
              if (addr_byte == 2'd2 && !is_write) tx <= mem[addr_shifted];
            end
            WRITE_DATA: begin
              if (!status_op) begin
                wr_stb   <= 1'b1;
                wr_addr  <= cur_addr;
                wr_byte  <= rx_next;
                cur_addr <= next_addr;
              end
`ifdef SPI_RAM_STATUS_EN
              else mode_reg <= rx_next;
`endif
            end
            READ_DATA: begin
              if (status_op) begin
                tx <= status_byte;
              end else begin
                cur_addr <= next_addr;
                tx       <= mem[next_addr];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign mem_we = byte_done && !ss_rise && (state == WRITE_DATA) && !status_op;

  // NOTE: the storage array has no reset; its contents are undefined until written.
  always_ff @(posedge clock) begin
    if (mem_we) mem[cur_addr] <= rx_next;
  end

  always_comb begin
    spi_miso_oe = (state == READ_DATA) && !ss_s;
    spi_miso    = spi_miso_oe ? miso_q : IDLE_MISO;
    busy        = armed && !ss_s;
  end

endmodule

// File: tb/tb_servant_spi_ram_slave.sv
// Directed bench for servant_spi_ram_slave: the bench acts as a mode-0 SPI master (half period 8 clocks).
module tb_servant_spi_ram_slave;
  localparam int AW   = 12;
  localparam int HALF = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          spi_sck = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
  logic          spi_miso, spi_miso_oe, busy, wr_stb;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_byte;

  servant_spi_ram_slave #(.MEM_ADDR_WIDTH(AW), .SYNC_STAGES(2), .IDLE_MISO(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_byte(wr_byte)
  );

  always #5 clock = ~clock;

  int            checks = 0, errors = 0;
  int            stb_count = 0;
  logic [AW-1:0] stb_addr_q[$];
  logic [7:0]    stb_byte_q[$];
  logic [7:0]    tx_q[$], rx_q[$];
  logic          oe_ok, miso_quiet, busy_mid;

  always @(negedge clock) begin
    if (wr_stb === 1'b1) begin
      stb_count++;
      stb_addr_q.push_back(wr_addr);
      stb_byte_q.push_back(wr_byte);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_stb();
    stb_count = 0;
    stb_addr_q = {};
    stb_byte_q = {};
  endtask

  task automatic spi_bit(input logic b, output logic m, output logic oe);
    spi_mosi = b;
    repeat (HALF) @(negedge clock);
    m  = spi_miso;
    oe = spi_miso_oe;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clock);
    spi_sck = 1'b0;
  endtask

  // Sends tx_q; bytes from index data_from on must see spi_miso_oe high, earlier ones low.
  task automatic xfer(input int data_from, input int extra_bits);
    logic m, oe;
    logic [7:0] r;
    rx_q = {};
    oe_ok = 1'b1;
    miso_quiet = 1'b1;
    r = 8'h00;
    spi_ss = 1'b0;
    foreach (tx_q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        spi_bit(tx_q[i][b], m, oe);
        r[b] = m;
        if (m !== 1'b0) miso_quiet = 1'b0;
        if (i < data_from && oe !== 1'b0) oe_ok = 1'b0;
        if (i >= data_from && oe !== 1'b1) oe_ok = 1'b0;
      end
      rx_q.push_back(r);
    end
    for (int b = 0; b < extra_bits; b++) spi_bit(1'b1, m, oe);
    repeat (HALF) @(negedge clock);
    busy_mid = busy;
    spi_ss = 1'b1;
    repeat (2 * HALF) @(negedge clock);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_rd [4];
    logic [31:0] word;
    logic        m, oe;

    repeat (5) @(negedge clock);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_waddr", {20'd0, wr_addr}, 32'd0);
    check("rst_wbyte", {24'd0, wr_byte}, 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);

    // 1: single byte write
    clear_stb();
    tx_q = {8'h02, 8'h00, 8'h00, 8'h10, 8'hA5};
    xfer(5, 0);
    check("t1_stb_cnt", stb_count, 1);
    check("t1_waddr", {20'd0, stb_addr_q[0]}, 32'h010);
    check("t1_wbyte", {24'd0, stb_byte_q[0]}, 32'hA5);
    check("t1_busy_mid", {31'd0, busy_mid}, 32'd1);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_oe", {31'd0, oe_ok}, 32'd1);

    // 2: fill 0x011..0x013 then read four bytes from 0x010
    clear_stb();
    tx_q = {8'h02, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h33};
    xfer(7, 0);
    check("t2_stb_cnt", stb_count, 3);
    check("t2_last_addr", {20'd0, stb_addr_q[2]}, 32'h013);
    tx_q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(4, 0);
    exp_rd = '{8'hA5, 8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 4; k++) check($sformatf("t2_rd%0d", k), {24'd0, rx_q[4+k]}, {24'd0, exp_rd[k]});
    check("t2_oe_window", {31'd0, oe_ok}, 32'd1);
    check("t2_oe_after", {31'd0, spi_miso_oe}, 32'd0);
    check("t2_miso_after", {31'd0, spi_miso}, 32'd0);

    // 3: write across the top of the decoded space
    clear_stb();
    tx_q = {8'h02, 8'h00, 8'h0F, 8'hFF, 8'hDE, 8'hAD};
    xfer(6, 0);
    check("t3_stb_cnt", stb_count, 2);
    check("t3_addr0", {20'd0, stb_addr_q[0]}, 32'hFFF);
    check("t3_addr1", {20'd0, stb_addr_q[1]}, 32'h000);
    check("t3_byte1", {24'd0, stb_byte_q[1]}, 32'hAD);
    tx_q = {8'h03, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00};
    xfer(4, 0);
    check("t3_rd_fff", {24'd0, rx_q[4]}, 32'hDE);
    check("t3_rd_000", {24'd0, rx_q[5]}, 32'hAD);

    // 4: partial write byte is discarded
    tx_q = {8'h02, 8'h00, 8'h00, 8'h20, 8'h5C};
    xfer(5, 0);
    clear_stb();
    tx_q = {8'h02, 8'h00, 8'h00, 8'h20};
    xfer(4, 5);
    check("t4_stb_cnt", stb_count, 0);
    tx_q = {8'h03, 8'h00, 8'h00, 8'h20, 8'h00};
    xfer(4, 0);
    check("t4_rd_020", {24'd0, rx_q[4]}, 32'h5C);

    // 5: unknown command, 32 more clocks
    clear_stb();
    tx_q = {8'h9F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    xfer(5, 0);
    check("t5_stb_cnt", stb_count, 0);
    check("t5_oe", {31'd0, oe_ok}, 32'd1);
    check("t5_miso_idle", {31'd0, miso_quiet}, 32'd1);

`ifdef SPI_RAM_STATUS_EN
    tx_q = {8'h05, 8'h00, 8'h00};
    xfer(1, 0);
    check("t5_rdsr0", {24'd0, rx_q[1]}, 32'h40);
    check("t5_rdsr1", {24'd0, rx_q[2]}, 32'h40);
`else
    tx_q = {8'h05, 8'h00};
    xfer(2, 0);
    check("t5_rdsr_ign_oe", {31'd0, oe_ok}, 32'd1);
    check("t5_rdsr_ign_miso", {31'd0, miso_quiet}, 32'd1);
`endif

    // 6: little-endian word 0xCAFEF00D at word address 0x40 (byte 0x100)
    clear_stb();
    tx_q = {8'h02, 8'h00, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    xfer(8, 0);
    check("t6_stb_cnt", stb_count, 4);
    tx_q = {8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(4, 0);
    word = {rx_q[7], rx_q[6], rx_q[5], rx_q[4]};
    check("t6_word", word, 32'hCAFEF00D);

    // 7: reset mid-transfer, select still low afterwards: sck activity is ignored
    spi_ss = 1'b0;
    repeat (HALF) @(negedge clock);
    spi_bit(1'b0, m, oe);
    spi_bit(1'b0, m, oe);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("t7_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    reset_n = 1'b1;
    clear_stb();
    tx_q = {8'h02, 8'h00, 8'h00, 8'h30, 8'h77};
    xfer(5, 0);
    check("t7_stb_cnt", stb_count, 0);
    check("t7_oe", {31'd0, oe_ok}, 32'd1);
    tx_q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
    xfer(4, 0);
    check("t7_recover_rd", {24'd0, rx_q[4]}, 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
